// File: rtl/code_ram_loader.sv
// rtl/code_ram_loader.sv - byte stream to code RAM loader (Avalon-MM debug-write master)
// Packs bytes little-endian into words, writes them with debugaccess, holds the CPU in reset meanwhile.
module code_ram_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 40000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_debugaccess,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_reset_req
);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DRAIN, FINISH} state_t;

  // One extra address bit so a wrap past the ADDR_W range still reads as out of bounds.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

  state_t          state, state_next;
  logic [ADDR_W:0] addr;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      lane;
  logic [31:0]     data;
  logic [3:0]      be;
  logic            last_pending;
  logic            error_q;

  logic byte_acc;
  logic word_end;
  logic addr_oob;

  assign byte_acc = s_valid && s_ready;
  assign word_end = (state == COLLECT) && byte_acc && ((lane == 2'd3) || s_last);
  assign addr_oob = (addr > LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = COLLECT;
      end
      COLLECT: begin
        // An out-of-range word never reaches WRITE: flag it and drain or finish.
        if (word_end) begin
          if (addr_oob) state_next = s_last ? FINISH : DRAIN;
          else          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) state_next = last_pending ? FINISH : COLLECT;
      end
      DRAIN: begin
        if (byte_acc && s_last) state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr         <= '0;
      word_cnt     <= '0;
      lane         <= '0;
      data         <= '0;
      be           <= '0;
      last_pending <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr         <= {1'b0, base_addr};
            word_cnt     <= '0;
            lane         <= '0;
            data         <= '0;
            be           <= '0;
            last_pending <= 1'b0;
            error_q      <= 1'b0;
          end
        end
        COLLECT: begin
          if (byte_acc) begin
            data[{lane, 3'b000} +: 8] <= s_data;
            be[lane]                  <= 1'b1;
            lane                      <= lane + 2'd1;
            if (word_end) begin
              last_pending <= s_last;
              if (addr_oob) begin
                error_q <= 1'b1;
                data    <= '0;
                be      <= '0;
                lane    <= '0;
              end
            end
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            word_cnt <= word_cnt + ONE;
            addr     <= addr + ONE;
            data     <= '0;
            be       <= '0;
            lane     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready         = (state == COLLECT) || (state == DRAIN);
  assign avm_write       = (state == WRITE);
  assign avm_chipselect  = (state == WRITE);
  assign avm_debugaccess = (state == WRITE);
  assign avm_address     = addr[ADDR_W-1:0];
  assign avm_writedata   = data;
  assign avm_byteenable  = be;
  assign busy            = (state == COLLECT) || (state == WRITE) || (state == DRAIN);
  assign done            = (state == FINISH);
  assign error           = error_q;
  assign word_count      = word_cnt;
  assign cpu_reset_req   = busy;

endmodule

// File: tb/tb_code_ram_loader.sv
// tb/tb_code_ram_loader.sv - randomized bench for code_ram_loader against a word-level load model
module tb_code_ram_loader;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 40000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic              avm_debugaccess;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;
  logic              cpu_reset_req;

  always #5 clk = ~clk;

  code_ram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_debugaccess(avm_debugaccess), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done), .error(error),
    .word_count(word_count), .cpu_reset_req(cpu_reset_req)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic [31:0] ram     [0:DEPTH-1];
  logic [31:0] exp_ram [0:DEPTH-1];
  wr_t         wr_log[$];
  wr_t         exp_q[$];
  logic [7:0]  stim[$];
  int          exp_wc;
  bit          exp_err;

  int   cyc = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0, stall_cycles = 0;
  int   wr_mode = 0, stall_left = 0;
  logic prev_stall = 1'b0;
  logic [15:0] p_addr;
  logic [31:0] p_data;
  logic [3:0]  p_be;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Slave model: applies accepted writes to ram and watches write-cycle invariants.
  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (avm_write && prev_stall) begin
      check("stall_addr", avm_address, p_addr);
      check("stall_data", avm_writedata, p_data);
      check("stall_be", avm_byteenable, p_be);
    end
    if (avm_write) begin
      check("ready_in_write", s_ready, 1'b0);
      check("cs_dbg_in_write", {avm_chipselect, avm_debugaccess}, 2'b11);
      if (avm_waitrequest) stall_cycles++;
    end
    if (avm_write && !avm_waitrequest) begin
      w.addr = avm_address; w.data = avm_writedata; w.be = avm_byteenable;
      wr_log.push_back(w);
      if (avm_address < DEPTH) ram[avm_address] = merge(ram[avm_address], avm_writedata, avm_byteenable);
      last_acc_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    prev_stall = avm_write && avm_waitrequest;
    p_addr = avm_address; p_data = avm_writedata; p_be = avm_byteenable;
  end

  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        0: avm_waitrequest = 1'b0;
        1: avm_waitrequest = ($urandom_range(0, 2) == 0);
        2: avm_waitrequest = 1'b1;
        default: begin
          avm_waitrequest = (stall_left > 0) && avm_write;
          if (avm_write && stall_left > 0) stall_left--;
        end
      endcase
    end
  end

  // Reference: chop the image into 4-byte words from base; stop at the first out-of-range word.
  task automatic build_ref(input int base);
    int a = base;
    exp_q.delete(); exp_wc = 0; exp_err = 0;
    for (int w = 0; w * 4 < stim.size(); w++) begin
      wr_t e;
      if (a > DEPTH - 1) begin exp_err = 1; break; end
      e.addr = a[15:0]; e.data = '0; e.be = '0;
      for (int k = 0; k < 4 && w * 4 + k < stim.size(); k++) begin
        e.data[8*k +: 8] = stim[w*4+k];
        e.be[k] = 1'b1;
      end
      exp_q.push_back(e); exp_wc++; a++;
    end
  endtask

  task automatic drive(input bit mid_start, input logic [15:0] alt_base);
    int idx = 0;
    int n = stim.size();
    bit acc;
    for (int c = 0; c < 3000 && idx < n; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = stim[idx];
      s_last  = (idx == n - 1);
      if (mid_start) begin
        start = (c == 2);
        if (c == 2) base_addr = alt_base;
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    start = 0; s_valid = 0; s_last = 0; s_data = 0;
    check("stream_consumed", idx, n);
  endtask

  task automatic run_load(input int base, input bit mid_start, input string name);
    bit got = 0;
    build_ref(base);
    wr_log.delete(); done_cnt = 0;
    base_addr = base[15:0]; start = 1;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    check({name, "_busy_rise"}, {busy, s_ready, cpu_reset_req}, 3'b111);
    check({name, "_start_clear"}, {error, word_count}, '0);
    check({name, "_start_addr"}, avm_address, base[15:0]);
    @(posedge clk); #1;
    drive(mid_start, base[15:0] ^ 16'h0155);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    check({name, "_done_seen"}, got, 1'b1);
    if (got) begin
      check({name, "_busy_fall"}, {busy, cpu_reset_req}, 2'b00);
      check({name, "_word_count"}, word_count, exp_wc);
      check({name, "_error"}, error, exp_err);
    end
    repeat (3) @(posedge clk); #1;
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_error_held"}, error, exp_err);
    check({name, "_num_writes"}, wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      check({name, "_write"}, wr_log[i], exp_q[i]);
    if (!exp_err && exp_q.size() > 0)
      check({name, "_done_latency"}, done_cyc - last_acc_cyc, 1);
    foreach (exp_q[i]) begin
      exp_ram[exp_q[i].addr] = merge(exp_ram[exp_q[i].addr], exp_q[i].data, exp_q[i].be);
      check({name, "_ram"}, ram[exp_q[i].addr], exp_ram[exp_q[i].addr]);
    end
  endtask

  initial begin
    reset = 1; start = 0; base_addr = 0; s_valid = 0; s_data = 0; s_last = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 32'h5A000000 ^ i;
      exp_ram[i] = 32'h5A000000 ^ i;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", s_ready, 1'b0);
    check("rst_avm_ctl", {avm_write, avm_chipselect, avm_debugaccess, avm_byteenable}, '0);
    check("rst_avm_addr_data", {avm_address, avm_writedata}, '0);
    check("rst_word_count", word_count, '0);
    check("rst_status", {busy, done, error, cpu_reset_req}, 4'b0000);
    @(posedge clk); #1; reset = 0;

    // Full words
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(16'h0010, 0, "full");
    if (wr_log.size() == 2) begin
      check("full_w0", wr_log[0], {16'h0010, 32'h44332211, 4'hF});
      check("full_w1", wr_log[1], {16'h0011, 32'h88776655, 4'hF});
    end

    // Partial tail over a preloaded word
    for (int i = 16'h0040; i < 16'h0042; i++) begin ram[i] = 32'hAAAAAAAA; exp_ram[i] = 32'hAAAAAAAA; end
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load(16'h0040, 0, "tail");
    check("tail_ram", ram[16'h0041], 32'hAAAA0605);

    // Waitrequest held high for 3 cycles on the first write
    stall_cycles = 0; stall_left = 3; wr_mode = 3;
    stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12};
    run_load(16'h0080, 0, "stall");
    check("stall_cycles", stall_cycles, 3);
    wr_mode = 0;

    // Overflow at the top of the RAM
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'(8'hC0 + i));
    run_load(DEPTH - 1, 0, "ovf");

    // Reset while a write is stalled
    wr_mode = 2;
    stim = '{8'h10, 8'h20, 8'h30, 8'h40};
    base_addr = 16'h0300; start = 1;
    @(posedge clk); #1; start = 0;
    drive(0, 16'h0);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (avm_write) begin seen = 1; break; end
      end
      check("rst_mid_write_seen", seen, 1'b1);
    end
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0; wr_mode = 0;
    @(negedge clk);
    check("rst_mid_outputs", {s_ready, avm_write, avm_chipselect, avm_debugaccess, avm_byteenable,
                              avm_address, avm_writedata, word_count, busy, done, error, cpu_reset_req}, '0);
    @(posedge clk); #1;
    stim = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    run_load(16'h0400, 0, "after_rst");

    // Start while busy must not disturb the address sequence
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
    run_load(16'h0120, 1, "restart");

    // Randomized loads with random stalls
    wr_mode = 1;
    for (int t = 0; t < 10; t++) begin
      int base;
      int len;
      if ($urandom_range(0, 2) == 0) base = DEPTH - 4 + $urandom_range(0, 6);
      else base = $urandom_range(0, DEPTH - 40);
      len = $urandom_range(1, 20);
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
      run_load(base, 0, "rand");
    end
    wr_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
